// File: rtl/stage5_control.sv
// Multi-cycle control FSM for the stage-5 datapath: fetch, decode, per-opcode execute/latch.
// Optional macro STAGE5_CTRL_INSTR_COUNT_EN adds the InstrCount retired-instruction counter.
module stage5_control #(
  parameter int         BOOT_DELAY = 5,
  parameter logic [3:0] OPC_HALT   = 4'hF
) (
  input  logic        CLK,
  input  logic        ResetN,
  input  logic        Run,
  input  logic        Stall,
  input  logic [15:0] IROut,
  output logic        MSPWrite,
  output logic        MSPop,
  output logic        RSPWrite,
  output logic        RSPop,
  output logic        PCWrite,
  output logic        PCSource,
  output logic        PCAdd,
  output logic        IRWrite,
  output logic        ValAWrite,
  output logic        ValBWrite,
  output logic        MemRead1,
  output logic        MemRead2,
  output logic        MemWrite1,
  output logic        MemWrite2,
  output logic [1:0]  MemDst1,
  output logic [1:0]  MemDst2,
  output logic [2:0]  MemData,
  output logic        Halted,
  output logic        Illegal,
`ifdef STAGE5_CTRL_INSTR_COUNT_EN
  output logic [15:0] InstrCount,
`endif
  output logic [2:0]  StateOut
);

  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    IDLE   = 3'd1,
    FETCH  = 3'd2,
    LATIR  = 3'd3,
    DECODE = 3'd4,
    EXEC   = 3'd5,
    LATCH  = 3'd6,
    HALT   = 3'd7
  } stateT;

  localparam int CntW = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
  localparam logic [CntW-1:0] BootLast = CntW'(BOOT_DELAY - 1);

  localparam logic [3:0] OpNop   = 4'd0;
  localparam logic [3:0] OpPopA  = 4'd1;
  localparam logic [3:0] OpLdB   = 4'd2;
  localparam logic [3:0] OpRPopA = 4'd3;
  localparam logic [3:0] OpJPop  = 4'd4;
  localparam logic [3:0] OpLdM   = 4'd5;
  localparam logic [3:0] OpBr    = 4'd6;
  localparam logic [3:0] OpSt    = 4'd7;

  stateT           state, nextState;
  logic [CntW-1:0] bootCnt;
  logic [3:0]      op;
  logic [3:0]      decodeOp;
  logic            decodeLegal;
  logic            unusedIrBits;

  logic mspWriteEn, rspWriteEn, pcWriteEn, irWriteEn, valAWriteEn, valBWriteEn;
  logic memRead1En, memRead2En, memWrite1En, illegalRaw;

  assign decodeOp     = IROut[15:12];
  assign decodeLegal  = (decodeOp <= OpSt) || (decodeOp == OPC_HALT);
  assign unusedIrBits = ^{IROut[11:10], IROut[7:3]};

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      state   <= BOOT;
      bootCnt <= '0;
      op      <= '0;
    end else if (!Stall) begin
      state <= nextState;
      if (state == BOOT)
        bootCnt <= bootCnt + CntW'(1);
      if (state == DECODE)
        op <= decodeOp;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      BOOT:   if (bootCnt == BootLast) nextState = IDLE;
      IDLE:   if (Run) nextState = FETCH;
      FETCH:  nextState = LATIR;
      LATIR:  nextState = DECODE;
      DECODE: begin
        if (decodeOp == OPC_HALT)
          nextState = HALT;
        else if (decodeOp == OpNop || !decodeLegal)
          nextState = FETCH;
        else
          nextState = EXEC;
      end
      EXEC:   nextState = (op == OpBr || op == OpSt) ? FETCH : LATCH;
      LATCH:  nextState = FETCH;
      HALT:   nextState = HALT;
      default: nextState = IDLE;
    endcase
    if (Stall)
      nextState = state;
  end

  // Enables are decoded raw here and gated by Stall below; selects pass through untouched.
  always_comb begin
    mspWriteEn  = 1'b0;
    rspWriteEn  = 1'b0;
    pcWriteEn   = 1'b0;
    irWriteEn   = 1'b0;
    valAWriteEn = 1'b0;
    valBWriteEn = 1'b0;
    memRead1En  = 1'b0;
    memRead2En  = 1'b0;
    memWrite1En = 1'b0;
    illegalRaw  = 1'b0;
    MSPop       = 1'b0;
    RSPop       = 1'b0;
    PCSource    = 1'b0;
    PCAdd       = 1'b0;
    MemDst1     = 2'b00;
    MemDst2     = 2'b00;
    MemData     = 3'b000;
    Halted      = 1'b0;
    case (state)
      FETCH: begin
        memRead1En = 1'b1;
        pcWriteEn  = 1'b1;
      end
      LATIR:  irWriteEn  = 1'b1;
      DECODE: illegalRaw = !decodeLegal;
      EXEC: begin
        case (op)
          OpPopA: begin
            memRead2En = 1'b1;
            mspWriteEn = 1'b1;
            MSPop      = 1'b1;
          end
          OpLdB: begin
            memRead1En = 1'b1;
            MemDst1    = 2'b01;
            mspWriteEn = 1'b1;
          end
          OpRPopA: begin
            memRead2En = 1'b1;
            MemDst2    = 2'b01;
            rspWriteEn = 1'b1;
            RSPop      = 1'b1;
          end
          OpJPop: begin
            memRead2En = 1'b1;
            mspWriteEn = 1'b1;
            MSPop      = 1'b1;
            pcWriteEn  = 1'b1;
            PCSource   = 1'b1;
          end
          OpLdM: begin
            memRead1En = 1'b1;
            MemDst1    = 2'b10;
          end
          OpBr: begin
            pcWriteEn = 1'b1;
            PCAdd     = 1'b1;
          end
          OpSt: begin
            memWrite1En = 1'b1;
            MemDst1     = IROut[9:8];
            MemData     = IROut[2:0];
          end
          default: ;
        endcase
      end
      LATCH: begin
        valAWriteEn = (op == OpPopA) || (op == OpRPopA) || (op == OpJPop);
        valBWriteEn = (op == OpLdB) || (op == OpLdM);
      end
      HALT: Halted = 1'b1;
      default: ;
    endcase
  end

  assign MSPWrite  = mspWriteEn  & ~Stall;
  assign RSPWrite  = rspWriteEn  & ~Stall;
  assign PCWrite   = pcWriteEn   & ~Stall;
  assign IRWrite   = irWriteEn   & ~Stall;
  assign ValAWrite = valAWriteEn & ~Stall;
  assign ValBWrite = valBWriteEn & ~Stall;
  assign MemRead1  = memRead1En  & ~Stall;
  assign MemRead2  = memRead2En  & ~Stall;
  assign MemWrite1 = memWrite1En & ~Stall;
  assign MemWrite2 = 1'b0;
  assign Illegal   = illegalRaw  & ~Stall;
  assign StateOut  = state;

`ifdef STAGE5_CTRL_INSTR_COUNT_EN
  // A retirement is any return to FETCH from the instruction body, never from IDLE.
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN)
      InstrCount <= '0;
    else if (!Stall && nextState == FETCH &&
             (state == DECODE || state == EXEC || state == LATCH))
      InstrCount <= InstrCount + 16'd1;
  end
`endif

endmodule

// File: doc/stage5_control.md
Name: stage5_control

Overview:
- Multi-cycle control FSM that sequences the stage-5 datapath (PC, IR, ValA/ValB, main and return stack pointers, dual-port memory).
- Fetches the instruction, decodes IROut[15:12], and drives every datapath enable/select for a fixed per-opcode cycle sequence.
- Sits directly beside stage5Integration and owns all of its control inputs.

Parameters:
- BOOT_DELAY, 5, cycles spent in BOOT after reset release before Run is sampled.
- OPC_HALT, 4'hF, opcode that enters HALT.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- ResetN  in  1  asynchronous active-low reset.
- Run  in  1  level; leave IDLE and start fetching.
- Stall  in  1  freeze FSM; all write/read enables forced 0.
- IROut  in  16  instruction register from datapath.
- MSPWrite, MSPop, RSPWrite, RSPop  out  1 each  stack pointer controls.
- PCWrite, PCSource, PCAdd  out  1 each  PC controls.
- IRWrite, ValAWrite, ValBWrite  out  1 each  register latches.
- MemRead1, MemRead2, MemWrite1, MemWrite2  out  1 each  memory port enables.
- MemDst1, MemDst2  out  2 each  port address selects.
- MemData  out  3  write-data select.
- Halted  out  1  high in HALT.
- Illegal  out  1  one-cycle pulse on undefined opcode.
- StateOut  out  3  current state encoding.

Behaviour:
- ResetN low: state=BOOT, boot counter=0, Op=0, all outputs 0 (Illegal=0, Halted=0), immediately and asynchronously.
- Outputs are Moore: decoded from state register and registered Op only.
- States and encodings: BOOT=0, IDLE=1, FETCH=2, LATIR=3, DECODE=4, EXEC=5, LATCH=6, HALT=7.
- BOOT: counts BOOT_DELAY cycles, then goes to IDLE. IDLE: goes to FETCH when Run=1.
- FETCH: MemRead1=1, MemDst1=00, PCWrite=1, PCSource=0, PCAdd=0 (PC<=PC+1) -> LATIR.
- LATIR: IRWrite=1 -> DECODE.
- DECODE: no enables; Op<=IROut[15:12]. Next state: HALT if Op==OPC_HALT; FETCH for NOP (0) and for undefined opcodes (Illegal pulses this cycle); otherwise EXEC.
- EXEC per Op:
  - 1 POPA: MemRead2, MemDst2=00, MSPWrite, MSPop=1.
  - 2 LDB: MemRead1, MemDst1=01, MSPWrite, MSPop=0.
  - 3 RPOPA: MemRead2, MemDst2=01, RSPWrite, RSPop=1.
  - 4 JPOP: MemRead2, MemDst2=00, MSPWrite, MSPop=1, PCWrite, PCSource=1.
  - 5 LDM: MemRead1, MemDst1=10.
  - 6 BR: PCWrite, PCAdd=1, PCSource=0.
  - 7 ST: MemWrite1, MemDst1=IR[9:8], MemData=IR[2:0].
  - Undefined opcodes 8-14 never reach EXEC.
- LATCH: ValAWrite for POPA/RPOPA/JPOP; ValBWrite for LDB/LDM. BR and ST skip LATCH: EXEC -> FETCH directly.
- Cycle counts per instruction: NOP 3, BR/ST 4, others 5.
- Stall=1: state, boot counter and Op hold; every enable (PCWrite, IRWrite, ValA/BWrite, Mem*, MSPWrite, RSPWrite) reads 0. Selects (MemDst*, PCSource, PCAdd, MSPop, RSPop, MemData) keep their state values. On Stall release the current state's controls are re-issued in full.
- Illegal is suppressed while stalled and is reissued on release.
- Run deasserted mid-instruction has no effect; it is sampled only in IDLE.
- HALT: all enables 0, Halted=1; left only by reset.
- Any unused StateOut encoding falls to IDLE.

Optional Feature:
- Macro STAGE5_CTRL_INSTR_COUNT_EN.
- Defined: adds output InstrCount[15:0], reset 0.
  - Increments by 1 on each transition into FETCH from DECODE or EXEC/LATCH (i.e., each retired instruction, including NOP and illegal).
  - Wraps 16'hFFFF -> 0; holds during Stall.
- Undefined: port absent, no counter logic.

Test Plan:
- Reset, BOOT_DELAY=5, Run=1 at cycle 2 -> StateOut stays 0 for 5 cycles, then 1, then FETCH on the cycle after IDLE; all outputs 0 throughout BOOT.
- IROut=16'h2000 (LDB) -> FETCH(PCWrite=1, MemRead1=1, MemDst1=00), LATIR(IRWrite=1), DECODE, EXEC(MemRead1=1, MemDst1=01, MSPWrite=1, MSPop=0), LATCH(ValBWrite=1), FETCH; 5 cycles.
- IROut=16'h4000 (JPOP) -> EXEC asserts PCWrite=1, PCSource=1, MSPWrite=1, MSPop=1, MemRead2=1, MemDst2=00; LATCH ValAWrite=1.
- IROut=16'h7205 (ST) -> EXEC MemWrite1=1, MemDst1=10, MemData=101, then FETCH with no LATCH; IROut=16'h9000 -> Illegal=1 for exactly 1 cycle in DECODE, then FETCH.
- Stall=1 for 3 cycles during EXEC of LDB -> StateOut=5 held, all enables 0, MemDst1=01 held; after release EXEC controls asserted for 1 cycle, then LATCH.
- IROut=16'hF000 -> HALT, Halted=1, no enables for 20 cycles despite Run=1; ResetN pulse low -> BOOT, Halted=0; with STAGE5_CTRL_INSTR_COUNT_EN, after 3 NOPs InstrCount=3.
